// File: rtl/cla8_pg_stage_if.sv
// rtl/cla8_pg_stage_if.sv - operand/result handshake bundle for the CLA propagate/generate stage
//
// Purpose: groups the input beat (in_valid/in_ready, a, b, carry_in, sub) and
//          the output beat (out_valid/out_ready, p, g, cin_out) of cla8_pg_stage.
// Ports (signals):
//   in_valid  : operand beat present (master -> slave)
//   in_ready  : stage can accept a beat (slave -> master)
//   a, b      : operands, WIDTH bits (master -> slave)
//   carry_in  : carry-in used for add (master -> slave)
//   sub       : 1 = compute a-b (master -> slave)
//   out_valid : p/g/cin_out valid (slave -> master)
//   out_ready : downstream accepts (master -> slave)
//   p, g      : propagate / generate bits, WIDTH bits (slave -> master)
//   cin_out   : effective carry-in c0 (slave -> master)
interface cla8_pg_stage_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;
   logic             cin_out;

   modport master (
      output in_valid, a, b, carry_in, sub, out_ready,
      input  in_ready, out_valid, p, g, cin_out
   );

   modport slave (
      input  in_valid, a, b, carry_in, sub, out_ready,
      output in_ready, out_valid, p, g, cin_out
   );
endinterface

// File: rtl/cla8_pg_stage.sv
// rtl/cla8_pg_stage.sv - registered propagate/generate front end of the 8-bit carry-lookahead adder
//
// Purpose: accepts operand beats, optionally turns a-b into a + ~b + 1, and
//          registers p = a ^ b_eff, g = a & b_eff and the effective carry-in
//          for the downstream carry cells. A two-entry skid buffer (output
//          register + skid register) sustains one beat per cycle under
//          backpressure while in_ready stays a plain register.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous, active-low reset
//   bus       : cla8_pg_stage_if slave modport (handshakes, operands, results)
//   txn_count : completed output handshakes, wraps at 2^CNT_W
module cla8_pg_stage #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   cla8_pg_stage_if.slave   bus,
   output logic [CNT_W-1:0] txn_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             in_ready_q;
   logic [CNT_W-1:0] txn_q;

   logic [WIDTH-1:0] out_p_q;
   logic [WIDTH-1:0] out_g_q;
   logic             out_cin_q;
   logic [WIDTH-1:0] skid_p_q;
   logic [WIDTH-1:0] skid_g_q;
   logic             skid_cin_q;

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] p_in;
   logic [WIDTH-1:0] g_in;
   logic             cin_in;

   logic accept;
   logic emit;
   logic load_out;
   logic load_skid;
   logic skid_to_out;

   // Subtraction is a + ~b + 1, so the carry-in is forced high.
   always_comb begin
      b_eff  = bus.sub ? ~bus.b : bus.b;
      cin_in = bus.sub | bus.carry_in;
      p_in   = bus.a ^ b_eff;
      g_in   = bus.a & b_eff;
   end

   assign accept = bus.in_valid & in_ready_q;
   assign emit   = (state_q != EMPTY) & bus.out_ready;

   always_comb begin
      state_d     = state_q;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d  = ONE;
               load_out = 1'b1;
            end
         end
         ONE: begin
            if (accept && emit) begin
               load_out = 1'b1;
            end else if (accept) begin
               state_d   = FULL;
               load_skid = 1'b1;
            end else if (emit) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so only the drain of the skid can happen.
            if (emit) begin
               state_d     = ONE;
               skid_to_out = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         txn_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != FULL);
         if (emit) begin
            txn_q <= txn_q + CNT_W'(1);
         end
      end
   end

   // Output register is not cleared on drain: p/g/cin_out keep the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_p_q    <= '0;
         out_g_q    <= '0;
         out_cin_q  <= 1'b0;
         skid_p_q   <= '0;
         skid_g_q   <= '0;
         skid_cin_q <= 1'b0;
      end else begin
         if (load_out) begin
            out_p_q   <= p_in;
            out_g_q   <= g_in;
            out_cin_q <= cin_in;
         end else if (skid_to_out) begin
            out_p_q   <= skid_p_q;
            out_g_q   <= skid_g_q;
            out_cin_q <= skid_cin_q;
         end
         if (load_skid) begin
            skid_p_q   <= p_in;
            skid_g_q   <= g_in;
            skid_cin_q <= cin_in;
         end else if (skid_to_out) begin
            skid_p_q   <= '0;
            skid_g_q   <= '0;
            skid_cin_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.p         = out_p_q;
   assign bus.g         = out_g_q;
   assign bus.cin_out   = out_cin_q;
   assign txn_count     = txn_q;

endmodule

// File: tb/tb_cla8_pg_stage.sv
// tb/tb_cla8_pg_stage.sv - self-checking bench for cla8_pg_stage
module tb_cla8_pg_stage;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] txn_count;

   int n_cmp = 0;
   int n_err = 0;

   cla8_pg_stage_if #(.WIDTH(8)) bus ();

   cla8_pg_stage #(.WIDTH(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .txn_count (txn_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] p;
      logic [7:0] g;
      logic       c;
   } beat_t;

   beat_t      mq[$];
   beat_t      m_last = '0;
   logic [7:0] m_txn = '0;

   function automatic beat_t beat_of(input logic [7:0] aa, input logic [7:0] bb,
                                     input logic c, input logic s);
      logic [7:0] be;
      be = s ? ~bb : bb;
      return {aa ^ be, aa & be, s | c};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a FIFO of at most two beats; the head is what the outputs show.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_last <= '0;
         m_txn  <= '0;
      end else if (mq.size() != 0 && bus.out_ready) begin
         m_last <= mq[0];
         m_txn  <= m_txn + 8'd1;
         if (bus.in_valid && mq.size() < 2) begin
            mq.pop_front();
            mq.push_back(beat_of(bus.a, bus.b, bus.carry_in, bus.sub));
         end else begin
            mq.pop_front();
         end
      end else if (bus.in_valid && mq.size() < 2) begin
         mq.push_back(beat_of(bus.a, bus.b, bus.carry_in, bus.sub));
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         beat_t e;
         e = (mq.size() != 0) ? mq[0] : m_last;
         chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
         chk("in_ready",  32'(bus.in_ready),  32'(mq.size() < 2));
         chk("p",         32'(bus.p),         32'(e.p));
         chk("g",         32'(bus.g),         32'(e.g));
         chk("cin_out",   32'(bus.cin_out),   32'(e.c));
         chk("txn_count", 32'(txn_count),     32'(m_txn));
      end
   end

   task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                        input logic c, input logic s);
      bus.in_valid = v;
      bus.a        = aa;
      bus.b        = bb;
      bus.carry_in = c;
      bus.sub      = s;
   endtask

   task automatic drive_rand(input logic v);
      drive(v, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
   endtask

   initial begin
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      bus.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_p",         32'(bus.p),         32'h00);
      chk("rst_g",         32'(bus.g),         32'h00);
      chk("rst_cin",       32'(bus.cin_out),   32'd0);
      chk("rst_txn",       32'(txn_count),     32'd0);
      rst_n = 1'b1;

      // add
      drive(1'b1, 8'h3C, 8'h0F, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("add_valid", 32'(bus.out_valid), 32'd1);
      chk("add_p",     32'(bus.p),         32'h33);
      chk("add_g",     32'(bus.g),         32'h0C);
      chk("add_cin",   32'(bus.cin_out),   32'd0);
      @(negedge clk);
      chk("add_txn",   32'(txn_count),     32'd1);
      chk("add_empty", 32'(bus.out_valid), 32'd0);

      // subtract
      drive(1'b1, 8'h10, 8'h01, 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("sub_p",   32'(bus.p),       32'hEE);
      chk("sub_g",   32'(bus.g),       32'h10);
      chk("sub_cin", 32'(bus.cin_out), 32'd1);
      chk("sub_sum", 32'(8'(bus.p + {bus.g[6:0], 1'b0} + 8'(bus.cin_out))), 32'h0F);
      @(negedge clk);
      chk("sub_txn", 32'(txn_count), 32'd2);

      // backpressure
      bus.out_ready = 1'b0;
      drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 8'h02, 8'h02, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 8'h55, 8'hAA, 1'b1, 1'b0);
      chk("bp_ready0", 32'(bus.in_ready), 32'd0);
      chk("bp_x_p",    32'(bus.p),        32'h00);
      chk("bp_x_g",    32'(bus.g),        32'h01);
      @(negedge clk);
      chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_g",     32'(bus.g),        32'h01);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_y_p",     32'(bus.p),         32'h00);
      chk("bp_y_g",     32'(bus.g),         32'h02);
      chk("bp_y_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_ready1",  32'(bus.in_ready),  32'd1);
      chk("bp_txn3",    32'(txn_count),     32'd3);
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("bp_z_p",   32'(bus.p),       32'hFF);
      chk("bp_z_g",   32'(bus.g),       32'h00);
      chk("bp_z_cin", 32'(bus.cin_out), 32'd1);
      @(negedge clk);
      chk("bp_txn5", 32'(txn_count), 32'd5);

      // streaming from a clean counter
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_rand(1'b1);
         @(negedge clk);
         chk("stream_ready", 32'(bus.in_ready), 32'd1);
      end
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("stream_txn10", 32'(txn_count), 32'd10);

      // counter wrap
      for (int i = 0; i < 246; i++) begin
         drive_rand(1'b1);
         @(negedge clk);
      end
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("wrap_txn0", 32'(txn_count), 32'h00);
      drive_rand(1'b1);
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("wrap_txn1", 32'(txn_count), 32'h01);

      // asynchronous reset while FULL
      bus.out_ready = 1'b0;
      drive_rand(1'b1);
      @(negedge clk);
      drive_rand(1'b1);
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("ar_full", 32'(bus.in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(bus.out_valid), 32'd0);
      chk("ar_ready", 32'(bus.in_ready),  32'd1);
      chk("ar_txn",   32'(txn_count),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ar_no_stale", 32'(bus.out_valid), 32'd0);
      end

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         drive_rand($urandom_range(0, 9) < 7);
         bus.out_ready = ($urandom_range(0, 9) < 6);
         @(negedge clk);
      end
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cla8_pg_stage.md
Name: cla8_pg_stage

Overview:
Registered front end of the 8-bit carry-lookahead adder. It accepts operand pairs over a valid/ready handshake and optionally converts subtraction to addition. It computes bitwise propagate/generate, then holds them with the effective carry-in stable for the downstream carry-logic group cells (c1..c8) and sum XORs. A 2-entry skid buffer lets the pipeline sustain one operation per cycle under backpressure without a combinational ready path.

Parameters:
WIDTH, 8, operand width; only 8 is supported and verified.
CNT_W, 8, width of the completed-transaction counter.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  operand beat present
in_ready  output  1  stage can accept a beat (registered)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
carry_in  input  1  carry-in used for add
sub  input  1  1 = compute A-B (B inverted, carry-in forced to 1)
out_valid  output  1  p/g/cin_out valid
out_ready  input  1  downstream accepts
p  output  WIDTH  propagate bits, p[i] = a[i] ^ b_eff[i]
g  output  WIDTH  generate bits, g[i] = a[i] & b_eff[i]
cin_out  output  1  effective carry-in (c0 for carry logic)
txn_count  output  CNT_W  number of completed output handshakes, wraps

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, in_ready=1, p=0, g=0, cin_out=0, txn_count=0, state=EMPTY, skid contents cleared. Deassertion is taken synchronously; first accept is possible on the first clk edge after deassertion.
- Compute, combinational on input side:
  - b_eff = sub ? ~b : b
  - cin_eff = sub ? 1 : carry_in
  - p = a ^ b_eff; g = a & b_eff
- Result registers are stored registered; there is no combinational path from inputs to outputs.
- Accept on in_valid & in_ready. Emit on out_valid & out_ready.
- Latency is 1 cycle: a beat accepted at edge N is visible at the outputs with out_valid=1 after edge N.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: output register holds a beat, out_valid=1, in_ready=1.
  - FULL: output and skid registers both hold beats, out_valid=1, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE (load output register).
  - ONE + accept, no emit -> FULL (load skid).
  - ONE + accept + emit -> ONE (output register reloaded with the new beat).
  - ONE + emit, no accept -> EMPTY.
  - FULL + emit -> ONE (skid moves to output register, skid cleared). No accept is possible in FULL.
- in_ready is a register equal to (next state != FULL).
- Output data is stable while out_valid=1 and out_ready=0. Order is strictly FIFO.
- txn_count increments by 1 on each emit and wraps 2^CNT_W-1 -> 0.
- When in_valid=0, a/b/sub/carry_in are ignored.
- p/g/cin_out hold their last values when the stage goes EMPTY; they are not cleared.
- Reset mid-operation: all held beats are discarded, nothing is emitted, and txn_count is cleared.

Test Plan:
- Add: a=0x3C, b=0x0F, carry_in=0, sub=0, out_ready=1 -> next cycle out_valid=1, p=0x33, g=0x0C, cin_out=0; txn_count=1 after the handshake.
- Subtract: a=0x10, b=0x01, sub=1, carry_in=0 -> p=0xEE, g=0x10, cin_out=1 (downstream sum = 0x0F).
- Backpressure:
  - Stimulus: hold out_ready=0, send beats X (0x01/0x01) and Y (0x02/0x02) back-to-back; later raise out_ready.
  - Response: in_ready=0 after Y with a third beat held off; outputs stay X (p=0x00, g=0x01) unchanged.
  - Drain: X then Y (p=0x00, g=0x02) emitted on consecutive cycles; in_ready returns to 1 after the first emit.
- Streaming: 10 consecutive beats with in_valid=1 and out_ready=1 every cycle -> one emit per cycle, in_ready never drops, results in order, txn_count=10.
- Wrap: 256 completed handshakes -> txn_count reads 0x00; one more -> 0x01.
- Async reset: assert rst_n=0 between clock edges while in FULL -> out_valid=0 and in_ready=1 immediately with no clk edge, txn_count=0; no stale beat emitted after release.
